// File: rtl/sony_imx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sony_imx_pkg
// Description : Shared constants and types for the Sony IMX sub-LVDS stream
//               generator: sync header bytes, pixel patterns and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package sony_imx_pkg;

    // Start-of-active-line header, emitted on every lane in this order
    localparam logic [7:0] SYNC_0 = 8'h7F;
    localparam logic [7:0] SYNC_1 = 8'h80;
    localparam logic [7:0] SYNC_2 = 8'h00;
    localparam logic [7:0] SYNC_3 = 8'h40;

    typedef enum logic [1:0] {
        PAT_ZERO  = 2'd0,
        PAT_INC   = 2'd1,
        PAT_FIXED = 2'd2,
        PAT_WALK  = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_VBLANK    = 3'd1,
        ST_HBLANK    = 3'd2,
        ST_ROW_DELAY = 3'd3,
        ST_SYNC      = 3'd4,
        ST_PAYLOAD   = 3'd5
    } state_e;

    // Header byte for word position idx within the 4-word sync sequence
    function automatic logic [7:0] sync_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return SYNC_0;
            2'd1:    return SYNC_1;
            2'd2:    return SYNC_2;
            default: return SYNC_3;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sony_imx_lane_pattern.sv
`default_nettype none
// ============================================================================
// Module      : sony_imx_lane_pattern
// Description : Combinational payload byte generator for one lane, given the
//               pattern, pixel index (low 8 bits), lane index and fixed byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sony_imx_lane_pattern
    import sony_imx_pkg::*;
(
    input  pattern_e   pattern_i,
    input  logic [7:0] pix_i,
    input  logic [7:0] lane_i,
    input  logic [7:0] fixed_i,
    output logic [7:0] byte_o
);

    logic [7:0] w_sum;

    // Pixel-plus-lane offset, naturally modulo 256
    assign w_sum = pix_i + lane_i;

    // Select the payload byte for the active pattern
    always_comb begin
        byte_o = 8'h00;
        case (pattern_i)
            PAT_ZERO:  byte_o = 8'h00;
            PAT_INC:   byte_o = w_sum;
            PAT_FIXED: byte_o = fixed_i;
            PAT_WALK:  byte_o = 8'h01 << w_sum[2:0];
            default:   byte_o = 8'h00;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sony_imx_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : sony_imx_stream_gen
// Description : Sony IMX parallel sub-LVDS stream transmitter. Generates VS,
//               HS and byte lanes with a sync header and selectable pattern.
// Revision    : 1.0 - initial release
// ============================================================================
module sony_imx_stream_gen
    import sony_imx_pkg::*;
#(
    parameter int LANE_WIDTH      = 8,
    parameter int ROW_START_DELAY = 10,
    parameter int CFG_WIDTH       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_enable,
    input  logic [CFG_WIDTH-1:0]    i_line_width,
    input  logic [CFG_WIDTH-1:0]    i_line_count,
    input  logic [CFG_WIDTH-1:0]    i_hblank,
    input  logic [CFG_WIDTH-1:0]    i_vblank,
    input  logic [1:0]              i_pattern,
    input  logic [7:0]              i_fixed_value,
    output logic                    o_vs,
    output logic                    o_hs,
    output logic [8*LANE_WIDTH-1:0] o_data,
    output logic                    o_busy,
    output logic [15:0]             o_frame_count
);

    localparam logic [CFG_WIDTH-1:0] c_ONE       = CFG_WIDTH'(1);
    localparam logic [CFG_WIDTH-1:0] c_SYNC_LAST = CFG_WIDTH'(3);
    localparam logic [CFG_WIDTH-1:0] c_ROW_LAST  =
        CFG_WIDTH'((ROW_START_DELAY > 0) ? ROW_START_DELAY - 1 : 0);
    localparam bit                   c_SKIP_ROW  = (ROW_START_DELAY == 0);

    state_e                  state_q, state_d;
    logic [CFG_WIDTH-1:0]    cnt_q, cnt_d;
    logic [CFG_WIDTH-1:0]    line_q, line_d;
    logic [15:0]             frame_count_q, frame_count_d;
    logic [CFG_WIDTH-1:0]    lw_q, lc_q, hb_q, vb_q;
    pattern_e                pat_q;
    logic [7:0]              fix_q;
    logic                    vs_q, hs_q, busy_q;
    logic                    vs_d, hs_d, busy_d;
    logic [8*LANE_WIDTH-1:0] data_q, data_d;
    logic                    w_load_cfg;
    logic                    w_eol;
    logic [7:0]              w_sync_byte;

    // Next state, cycle/line counters, frame counter and config-load strobe
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        line_d        = line_q;
        frame_count_d = frame_count_q;
        w_load_cfg    = 1'b0;
        w_eol         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    w_load_cfg = 1'b1;
                    state_d    = ST_VBLANK;
                    cnt_d      = '0;
                end
            end
            ST_VBLANK: begin
                cnt_d = cnt_q + c_ONE;
                if (cnt_q == vb_q - c_ONE) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                    line_d  = '0;
                end
            end
            ST_HBLANK: begin
                cnt_d = cnt_q + c_ONE;
                if (cnt_q == hb_q - c_ONE) begin
                    cnt_d   = '0;
                    state_d = c_SKIP_ROW ? ST_SYNC : ST_ROW_DELAY;
                end
            end
            ST_ROW_DELAY: begin
                cnt_d = cnt_q + c_ONE;
                if (cnt_q == c_ROW_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                cnt_d = cnt_q + c_ONE;
                if (cnt_q == c_SYNC_LAST) begin
                    cnt_d = '0;
                    if (lw_q == '0) begin
                        w_eol = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                cnt_d = cnt_q + c_ONE;
                if (cnt_q == lw_q - c_ONE) begin
                    w_eol = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // End of line: next line, or close the frame and restart/stop
        if (w_eol) begin
            cnt_d  = '0;
            line_d = line_q + c_ONE;
            if (line_q + c_ONE != lc_q) begin
                state_d = ST_HBLANK;
            end else begin
                frame_count_d = frame_count_q + 16'd1;
                if (i_enable) begin
                    w_load_cfg = 1'b1;
                    state_d    = ST_VBLANK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    // Output levels are decoded from the next state so they register in step
    always_comb begin
        vs_d   = state_d inside {ST_HBLANK, ST_ROW_DELAY, ST_SYNC, ST_PAYLOAD};
        hs_d   = state_d inside {ST_ROW_DELAY, ST_SYNC, ST_PAYLOAD};
        busy_d = (state_d != ST_IDLE);
    end

    assign w_sync_byte = sync_byte(cnt_d[1:0]);

    generate
        for (genvar k = 0; k < LANE_WIDTH; k++) begin : g_lane
            logic [7:0] w_lane_byte;

            sony_imx_lane_pattern u_pattern (
                .pattern_i (pat_q),
                .pix_i     (cnt_d[7:0]),
                .lane_i    (8'(k)),
                .fixed_i   (fix_q),
                .byte_o    (w_lane_byte)
            );

            assign data_d[8*k +: 8] = (state_d == ST_PAYLOAD) ? w_lane_byte :
                                      (state_d == ST_SYNC)    ? w_sync_byte : 8'h00;
        end
    endgenerate

    // State, counters, latched (clamped) config and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            line_q        <= '0;
            frame_count_q <= '0;
            lw_q          <= '0;
            lc_q          <= c_ONE;
            hb_q          <= c_ONE;
            vb_q          <= c_ONE;
            pat_q         <= PAT_ZERO;
            fix_q         <= 8'h00;
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            busy_q        <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            line_q        <= line_d;
            frame_count_q <= frame_count_d;
            vs_q          <= vs_d;
            hs_q          <= hs_d;
            busy_q        <= busy_d;
            data_q        <= data_d;
            if (w_load_cfg) begin
                lw_q  <= i_line_width;
                lc_q  <= (i_line_count == '0) ? c_ONE : i_line_count;
                hb_q  <= (i_hblank == '0)     ? c_ONE : i_hblank;
                vb_q  <= (i_vblank == '0)     ? c_ONE : i_vblank;
                pat_q <= pattern_e'(i_pattern);
                fix_q <= i_fixed_value;
            end
        end
    end

    assign o_vs          = vs_q;
    assign o_hs          = hs_q;
    assign o_data        = data_q;
    assign o_busy        = busy_q;
    assign o_frame_count = frame_count_q;

endmodule
`default_nettype wire

// File: tb/tb_sony_imx_stream_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sony_imx_stream_gen
// Description : Self-checking bench for sony_imx_stream_gen. Expected frames
//               are built cycle by cycle from the stream format rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sony_imx_stream_gen;

    localparam int LW  = 8;
    localparam int RSD = 10;
    localparam int CW  = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_enable;
    logic [CW-1:0]   i_line_width, i_line_count, i_hblank, i_vblank;
    logic [1:0]      i_pattern;
    logic [7:0]      i_fixed_value;
    logic            o_vs, o_hs, o_busy;
    logic [8*LW-1:0] o_data;
    logic [15:0]     o_frame_count;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] fc_model = 16'h0;
    int          m_lw, m_lc, m_hb, m_vb, m_pat;
    logic [7:0]  m_fix;

    always #5 clk = ~clk;

    sony_imx_stream_gen #(
        .LANE_WIDTH      (LW),
        .ROW_START_DELAY (RSD),
        .CFG_WIDTH       (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .i_enable      (i_enable),
        .i_line_width  (i_line_width),
        .i_line_count  (i_line_count),
        .i_hblank      (i_hblank),
        .i_vblank      (i_vblank),
        .i_pattern     (i_pattern),
        .i_fixed_value (i_fixed_value),
        .o_vs          (o_vs),
        .o_hs          (o_hs),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_frame_count (o_frame_count)
    );

    // Compare {busy, vs, hs, data, frame_count} against an expected vector
    task automatic chk(input logic [82:0] exp, input string tag);
        logic [82:0] obs;
        obs = {o_busy, o_vs, o_hs, o_data, o_frame_count};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat_byte(input int pat, input logic [7:0] fix,
                                            input int p, input int k);
        case (pat)
            0:       return 8'h00;
            1:       return 8'((p + k) % 256);
            2:       return fix;
            default: return 8'(1 << ((p + k) % 8));
        endcase
    endfunction

    task automatic set_cfg(input int lw, input int lc, input int hb, input int vb,
                           input int pat, input logic [7:0] fix);
        m_lw = lw; m_lc = lc; m_hb = hb; m_vb = vb; m_pat = pat; m_fix = fix;
        i_line_width  = CW'(lw);
        i_line_count  = CW'(lc);
        i_hblank      = CW'(hb);
        i_vblank      = CW'(vb);
        i_pattern     = 2'(pat);
        i_fixed_value = fix;
    endtask

    // Build the expected frame from the model config and check every cycle.
    // After cycle 'mid' the config inputs are scrambled (line width set to
    // mid_lw, enable dropped if 'drop'); stop_after>0 ends the check early.
    task automatic check_frame(input int mid, input int mid_lw, input bit drop,
                               input int stop_after, input string tag);
        logic [65:0] q[$];
        logic [63:0] d;
        int lc, hb, vb;
        bit stopped;
        lc = (m_lc == 0) ? 1 : m_lc;
        hb = (m_hb == 0) ? 1 : m_hb;
        vb = (m_vb == 0) ? 1 : m_vb;
        q.delete();
        repeat (vb) q.push_back({2'b00, 64'h0});
        for (int l = 0; l < lc; l++) begin
            repeat (hb)  q.push_back({2'b10, 64'h0});
            repeat (RSD) q.push_back({2'b11, 64'h0});
            q.push_back({2'b11, {LW{8'h7F}}});
            q.push_back({2'b11, {LW{8'h80}}});
            q.push_back({2'b11, {LW{8'h00}}});
            q.push_back({2'b11, {LW{8'h40}}});
            for (int p = 0; p < m_lw; p++) begin
                for (int k = 0; k < LW; k++) d[8*k +: 8] = pat_byte(m_pat, m_fix, p, k);
                q.push_back({2'b11, d});
            end
        end
        stopped = 1'b0;
        for (int i = 0; i < q.size() && !stopped; i++) begin
            @(negedge clk);
            chk({1'b1, q[i], fc_model}, tag);
            if (mid != 0 && i + 1 == mid) begin
                i_line_width  = CW'(mid_lw);
                i_line_count  = CW'($urandom_range(0, 5));
                i_hblank      = CW'($urandom_range(0, 5));
                i_vblank      = CW'($urandom_range(0, 5));
                i_pattern     = 2'($urandom_range(0, 3));
                i_fixed_value = 8'($urandom);
                if (drop) i_enable = 1'b0;
            end
            if (stop_after != 0 && i + 1 == stop_after) stopped = 1'b1;
        end
        if (!stopped) fc_model = fc_model + 16'd1;
    endtask

    initial begin
        rst = 1'b1;
        i_enable = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 8'h00);
        repeat (3) @(negedge clk);
        chk('0, "reset_state");
        rst = 1'b0;
        @(negedge clk);
        chk('0, "idle_disabled");

        // Default frame: 5 VBLANK, 2 lines of 22 HS cycles, incrementing pattern
        i_enable = 1'b1;
        set_cfg(8, 2, 3, 5, 1, 8'h00);
        check_frame(3, 8, 1'b0, 0, "default_frame");

        // Fixed pattern with no payload: header-only lines
        set_cfg(0, 2, 3, 5, 2, 8'hA5);
        check_frame(7, 3, 1'b0, 0, "fixed_lw0");

        // Zero blanking and line count clamp to one
        set_cfg(3, 0, 0, 0, 3, 8'h00);
        check_frame(2, 9, 1'b0, 0, "clamp_min");

        // Line width changed mid-frame only applies to the next frame
        set_cfg(8, 2, 2, 3, 1, 8'h00);
        check_frame(10, 4, 1'b0, 0, "lw8_midchange");
        set_cfg(4, 2, 2, 3, 1, 8'h00);
        check_frame(0, 0, 1'b0, 0, "lw4_next");

        // Randomised back-to-back frames
        for (int f = 0; f < 16; f++) begin
            set_cfg($urandom_range(0, 12), $urandom_range(0, 3), $urandom_range(0, 4),
                    $urandom_range(0, 4), $urandom_range(0, 3), 8'($urandom));
            check_frame($urandom_range(1, 16), $urandom_range(0, 20), 1'b0, 0, "rand_frame");
        end

        // Enable dropped during line 1 of 2: frame completes, then idle
        set_cfg(6, 2, 3, 4, 3, 8'h00);
        check_frame(4 + 3 + 5, 6, 1'b1, 0, "drop_enable");
        @(negedge clk);
        chk({3'b000, 64'h0, fc_model}, "idle_after_drop");
        @(negedge clk);
        chk({3'b000, 64'h0, fc_model}, "idle_hold");

        // Reset during payload (pixel 2 of line 0)
        i_enable = 1'b1;
        set_cfg(8, 2, 3, 5, 1, 8'h00);
        check_frame(0, 0, 1'b0, 5 + 3 + RSD + 4 + 3, "pre_reset");
        rst = 1'b1;
        i_enable = 1'b0;
        @(negedge clk);
        chk('0, "reset_in_payload");
        fc_model = 16'h0;
        rst = 1'b0;
        @(negedge clk);
        chk('0, "idle_after_reset");

        // Frame counter wrap: preload near the top, then run minimal frames
        force dut.frame_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.frame_count_q;
        fc_model = 16'hFFFE;
        @(negedge clk);
        chk({3'b000, 64'h0, fc_model}, "preload_hold");
        i_enable = 1'b1;
        set_cfg(0, 0, 0, 0, 2, 8'h3C);
        check_frame(0, 0, 1'b0, 0, "wrap_ffff");
        check_frame(2, 0, 1'b1, 0, "wrap_zero");
        @(negedge clk);
        chk({3'b000, 64'h0, 16'h0000}, "wrap_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
